// File: rtl/aibcr3_dll_lock_ctrl.sv
// DLL lock controller: linear coarse search, fine search, then filtered +/-1 tracking
// of the 9-bit {coarse, fine} delay code, driven out as Gray codes with a change strobe.
module aibcr3_dll_lock_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int FILT_LEN   = 4,
    parameter int COARSE_MAX = 63
) (
    input  logic       CLKIN,
    input  logic       RSTb,
    input  logic       dll_en,
    input  logic       pd_up,
    output logic [6:0] grey,
    output logic [2:0] i_gray,
    output logic       code_valid,
    output logic       dll_lock,
    output logic       lock_err
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [5:0]    CMAX       = 6'(COARSE_MAX);
    localparam logic [8:0]    LIN_MAX    = {CMAX, 3'd7};
    localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE_CYC);
    localparam logic [SW-1:0] SETTLE_ONE = SW'(1);
    localparam logic [FW-1:0] FILT_TGT   = FW'(FILT_LEN);
    localparam logic [FW-1:0] FILT_ONE   = FW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CSRCH  = 3'd1,
        ST_FSRCH  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    function automatic logic [6:0] gray7(input logic [6:0] b);
        return b ^ {1'b0, b[6:1]};
    endfunction

    function automatic logic [2:0] gray3(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction

    state_t        r_state, w_state_nxt;
    logic [8:0]    r_lin, w_lin_nxt;
    logic [SW-1:0] r_settle, w_settle_nxt;
    logic [FW-1:0] r_filt, w_filt_nxt, w_run;
    logic          r_filt_val, w_filt_val_nxt;
    logic          r_chg, w_chg;
    logic          w_reload, w_entry, w_sample;
    logic [5:0]    w_coarse;

    assign w_coarse = r_lin[8:3];
    assign w_sample = (r_settle == {SW{1'b0}});

    // Next state, next code, settle reload and tracking filter
    always_comb begin
        w_state_nxt    = r_state;
        w_lin_nxt      = r_lin;
        w_filt_nxt     = r_filt;
        w_filt_val_nxt = r_filt_val;
        w_reload       = 1'b0;
        w_entry        = 1'b0;
        w_run          = ((r_filt != {FW{1'b0}}) && (pd_up == r_filt_val)) ? (r_filt + FILT_ONE) : FILT_ONE;
        if (!dll_en) begin
            w_state_nxt    = ST_IDLE;
            w_lin_nxt      = 9'd0;
            w_filt_nxt     = {FW{1'b0}};
            w_filt_val_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_CSRCH;
                    w_lin_nxt   = 9'd0;
                    w_entry     = 1'b1;
                    w_reload    = 1'b1;
                end
                ST_CSRCH: begin
                    if (!w_sample) begin
                        w_state_nxt = r_state;
                    end else if (pd_up && (w_coarse < CMAX)) begin
                        w_lin_nxt = {w_coarse + 6'd1, 3'd0};
                        w_reload  = 1'b1;
                    end else if (pd_up) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        // Step back to the last coarse code that was still too short
                        w_state_nxt = ST_FSRCH;
                        w_reload    = 1'b1;
                        w_lin_nxt   = (w_coarse == 6'd0) ? r_lin : {w_coarse - 6'd1, 3'd0};
                    end
                end
                ST_FSRCH: begin
                    if (!w_sample) begin
                        w_state_nxt = r_state;
                    end else if (!pd_up) begin
                        w_state_nxt = ST_LOCKED;
                        w_filt_nxt  = {FW{1'b0}};
                    end else if (r_lin == LIN_MAX) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_lin_nxt = r_lin + 9'd1;
                        w_reload  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_sample) begin
                        w_state_nxt = r_state;
                    end else begin
                        w_filt_val_nxt = pd_up;
                        if (w_run != FILT_TGT) begin
                            w_filt_nxt = w_run;
                        end else begin
                            w_filt_nxt = {FW{1'b0}};
                            if (pd_up && (r_lin != LIN_MAX)) begin
                                w_lin_nxt = r_lin + 9'd1;
                                w_reload  = 1'b1;
                            end else if (!pd_up && (r_lin != 9'd0)) begin
                                w_lin_nxt = r_lin - 9'd1;
                                w_reload  = 1'b1;
                            end else begin
                                w_reload = 1'b0;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    w_state_nxt = ST_ERR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_lin_nxt   = 9'd0;
                end
            endcase
        end
        w_chg = w_entry || (w_lin_nxt != r_lin);
        if (!dll_en) begin
            w_settle_nxt = {SW{1'b0}};
        end else if (w_reload) begin
            w_settle_nxt = SETTLE_LD;
        end else if (w_sample) begin
            w_settle_nxt = r_settle;
        end else begin
            w_settle_nxt = r_settle - SETTLE_ONE;
        end
    end

    // State/code registers and registered outputs; code_valid trails the code change by one cycle
    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) begin
            r_state    <= ST_IDLE;
            r_lin      <= 9'd0;
            r_settle   <= {SW{1'b0}};
            r_filt     <= {FW{1'b0}};
            r_filt_val <= 1'b0;
            r_chg      <= 1'b0;
            code_valid <= 1'b0;
            grey       <= 7'd0;
            i_gray     <= 3'd0;
            dll_lock   <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lin      <= w_lin_nxt;
            r_settle   <= w_settle_nxt;
            r_filt     <= w_filt_nxt;
            r_filt_val <= w_filt_val_nxt;
            r_chg      <= w_chg;
            code_valid <= r_chg;
            grey       <= gray7({1'b0, w_lin_nxt[8:3]});
            i_gray     <= gray3(w_lin_nxt[2:0]);
            dll_lock   <= (w_state_nxt == ST_LOCKED);
            lock_err   <= (w_state_nxt == ST_ERR);
        end
    end
endmodule

// File: tb/tb_aibcr3_dll_lock_ctrl.sv
// Bench for aibcr3_dll_lock_ctrl: an abstract lock-sequence model checked every cycle,
// a simple phase-detector plant for stimulus, and hand-computed literal checkpoints.
module tb_aibcr3_dll_lock_ctrl;
    localparam int SETTLE = 16;
    localparam int FILT   = 4;
    localparam int CMAX   = 63;
    localparam int M_IDLE = 0, M_CSRCH = 1, M_FSRCH = 2, M_LOCKED = 3, M_ERR = 4;

    logic       CLKIN  = 1'b0;
    logic       RSTb   = 1'b0;
    logic       dll_en = 1'b0;
    logic       pd_up  = 1'b0;
    logic [6:0] grey;
    logic [2:0] i_gray;
    logic       code_valid, dll_lock, lock_err;

    aibcr3_dll_lock_ctrl #(.SETTLE_CYC(SETTLE), .FILT_LEN(FILT), .COARSE_MAX(CMAX)) dut (
        .CLKIN(CLKIN), .RSTb(RSTb), .dll_en(dll_en), .pd_up(pd_up),
        .grey(grey), .i_gray(i_gray), .code_valid(code_valid),
        .dll_lock(dll_lock), .lock_err(lock_err)
    );

    always #5 CLKIN = ~CLKIN;

    int pass_cnt = 0, total_cnt = 0;
    bit cmp_on = 1'b0;

    // Abstract model: state as a number, code as an integer 0..511
    int   m_st = M_IDLE, m_lin = 0, m_wait = 0, m_run = 0, m_old = 0;
    logic m_last = 1'b0, m_chg = 1'b0, m_cv = 1'b0, m_entry = 1'b0;

    task m_move(input int v);
        m_lin  = v;
        m_wait = SETTLE;
    endtask

    initial forever begin
        @(posedge CLKIN or negedge RSTb);
        if (!RSTb) begin
            m_st = M_IDLE; m_lin = 0; m_wait = 0; m_run = 0;
            m_last = 1'b0; m_chg = 1'b0; m_cv = 1'b0;
        end else begin
            m_cv = m_chg; m_old = m_lin; m_entry = 1'b0;
            if (!dll_en) begin
                m_st = M_IDLE; m_lin = 0; m_wait = 0; m_run = 0;
            end else if (m_st == M_IDLE) begin
                m_st = M_CSRCH; m_wait = SETTLE; m_entry = 1'b1;
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (m_st == M_CSRCH) begin
                if (pd_up) begin
                    if (m_lin / 8 < CMAX) m_move(m_lin + 8);
                    else m_st = M_ERR;
                end else begin
                    m_st = M_FSRCH; m_wait = SETTLE;
                    if (m_lin > 0) m_move(m_lin - 8);
                end
            end else if (m_st == M_FSRCH) begin
                if (!pd_up) begin m_st = M_LOCKED; m_run = 0; end
                else if (m_lin == CMAX * 8 + 7) m_st = M_ERR;
                else m_move(m_lin + 1);
            end else if (m_st == M_LOCKED) begin
                m_run  = (m_run > 0 && pd_up == m_last) ? m_run + 1 : 1;
                m_last = pd_up;
                if (m_run == FILT) begin
                    m_run = 0;
                    if (pd_up && m_lin < CMAX * 8 + 7) m_move(m_lin + 1);
                    else if (!pd_up && m_lin > 0) m_move(m_lin - 1);
                end
            end
            m_chg = m_entry || (m_lin != m_old);
        end
    end

    function automatic logic [12:0] exp_out();
        int c, f;
        c = m_lin / 8;
        f = m_lin % 8;
        return {7'(c ^ (c / 2)), 3'(f ^ (f / 2)), m_cv, (m_st == M_LOCKED), (m_st == M_ERR)};
    endfunction

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge CLKIN);
        if (cmp_on) begin
            total_cnt++;
            if ({grey, i_gray, code_valid, dll_lock, lock_err} === exp_out()) pass_cnt++;
            else $display("FAIL model_cmp t=%0t: got {grey,i_gray,cv,lock,err}=%b want %b",
                          $time, {grey, i_gray, code_valid, dll_lock, lock_err}, exp_out());
        end
    end

    int cyc_no = 0, cv_cnt = 0, last_cv = -1, bad_gap = 0;
    bit gap_chk = 1'b0;
    initial forever begin
        @(negedge CLKIN);
        cyc_no++;
        if (code_valid === 1'b1) begin
            cv_cnt++;
            if (gap_chk && last_cv >= 0 && (cyc_no - last_cv) != SETTLE + 1) bad_gap++;
            last_cv = cyc_no;
        end
    end

    bit   pd_force = 1'b1;
    logic pd_val   = 1'b0;
    int   c_tgt = 0, l_tgt = 0;

    task drive_pd();
        if (pd_force) pd_up = pd_val;
        else if (m_st == M_CSRCH) pd_up = (m_lin / 8 < c_tgt);
        else pd_up = (m_lin < l_tgt);
    endtask

    task cyc();
        @(negedge CLKIN);
        #1;
        drive_pd();
    endtask

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task wait_st(input int st, input int budget, input string name);
        int n;
        n = 0;
        while (m_st != st && n < budget) begin cyc(); n++; end
        if (m_st != st) begin
            total_cnt++;
            $display("FAIL %s: timeout after %0d cycles, state %0d want %0d", name, n, m_st, st);
        end
    endtask

    task wait_lin(input int v, input int budget, input string name);
        int n;
        n = 0;
        while (m_lin != v && n < budget) begin cyc(); n++; end
        if (m_lin != v) begin
            total_cnt++;
            $display("FAIL %s: timeout after %0d cycles, code %0d want %0d", name, n, m_lin, v);
        end
    endtask

    initial begin
        repeat (2) cyc();
        cmp_on = 1'b1;
        chk("reset_outputs", 32'({grey, i_gray, code_valid, dll_lock, lock_err}), 32'd0);
        RSTb = 1'b1;
        cyc();

        // 1: coarse climbs to 10, backs off to 9, locks at {9,0}
        c_tgt = 10; l_tgt = 72; pd_force = 1'b0; gap_chk = 1'b1; dll_en = 1'b1; drive_pd();
        wait_st(M_LOCKED, 1000, "t1_lock");
        gap_chk = 1'b0; pd_force = 1'b1; pd_val = 1'b1; drive_pd();
        chk("t1_grey", 32'(grey), 32'(7'b0001101));
        chk("t1_igray", 32'(i_gray), 32'd0);
        chk("t1_dll_lock", 32'(dll_lock), 32'd1);
        chk("t1_cv_count", cv_cnt, 32'd12);
        chk("t1_step_spacing", bad_gap, 32'd0);

        // 2: FILT-1 ones then a zero give no step; a sustained run carries {9,7} into {10,0}
        cyc(); cyc(); cyc();
        pd_val = 1'b0; drive_pd();
        cyc();
        pd_val = 1'b1; drive_pd();
        chk("t2_short_run_grey", 32'(grey), 32'(7'b0001101));
        chk("t2_short_run_igray", 32'(i_gray), 32'd0);
        wait_lin(80, 600, "t2_carry");
        chk("t2_carry_grey", 32'(grey), 32'(7'b0001111));
        chk("t2_carry_igray", 32'(i_gray), 32'(3'b000));
        dll_en = 1'b0;
        repeat (3) cyc();

        // 3: pd_up stuck high walks coarse to the top and errors out
        c_tgt = 64; l_tgt = 512; pd_force = 1'b0; dll_en = 1'b1; drive_pd();
        wait_st(M_ERR, 1500, "t3_err");
        chk("t3_lock_err", 32'(lock_err), 32'd1);
        chk("t3_dll_lock", 32'(dll_lock), 32'd0);
        chk("t3_grey_top", 32'(grey), 32'(7'b0100000));
        repeat (20) cyc();
        chk("t3_err_sticky", 32'(lock_err), 32'd1);
        dll_en = 1'b0;
        repeat (3) cyc();
        chk("t3_disable_clear", 32'({grey, i_gray, code_valid, dll_lock, lock_err}), 32'd0);

        // 4a: locked at code 0 with pd_up low saturates silently
        c_tgt = 0; l_tgt = 0; dll_en = 1'b1; drive_pd();
        wait_st(M_LOCKED, 100, "t4a_lock");
        pd_force = 1'b1; pd_val = 1'b0; drive_pd(); cv_cnt = 0;
        repeat (30) cyc();
        chk("t4a_no_strobe", cv_cnt, 32'd0);
        chk("t4a_code", 32'({grey, i_gray}), 32'd0);
        chk("t4a_lock", 32'(dll_lock), 32'd1);
        dll_en = 1'b0;
        repeat (2) cyc();

        // 4b: locked at {63,7} with pd_up high saturates silently
        pd_force = 1'b0; c_tgt = 63; l_tgt = 511; dll_en = 1'b1; drive_pd();
        wait_st(M_LOCKED, 3000, "t4b_lock");
        pd_force = 1'b1; pd_val = 1'b1; drive_pd(); cv_cnt = 0;
        repeat (30) cyc();
        chk("t4b_no_strobe", cv_cnt, 32'd0);
        chk("t4b_grey", 32'(grey), 32'(7'b0100000));
        chk("t4b_igray", 32'(i_gray), 32'(3'b100));
        chk("t4b_lock", 32'(dll_lock), 32'd1);
        dll_en = 1'b0;
        repeat (3) cyc();

        // 5: disable during fine search at {20,3}, then restart from zero
        pd_force = 1'b0; c_tgt = 21; l_tgt = 512; dll_en = 1'b1; drive_pd();
        wait_lin(163, 1000, "t5_reach");
        chk("t5_grey_20", 32'(grey), 32'(7'b0011110));
        chk("t5_igray_3", 32'(i_gray), 32'(3'b010));
        dll_en = 1'b0;
        cyc();
        cv_cnt = 0;
        chk("t5_idle_code", 32'({grey, i_gray, dll_lock}), 32'd0);
        repeat (3) cyc();
        chk("t5_one_strobe", cv_cnt, 32'd1);
        c_tgt = 64; dll_en = 1'b1; drive_pd();
        repeat (17) cyc();
        chk("t5_restart_hold", 32'(grey), 32'd0);
        cyc();
        chk("t5_restart_step", 32'(grey), 32'(7'b0000001));

        // 6: asynchronous reset mid coarse search
        repeat (40) cyc();
        #2;
        RSTb = 1'b0;
        #1;
        chk("t6_async_clear", 32'({grey, i_gray, code_valid, dll_lock, lock_err}), 32'd0);
        cyc();
        dll_en = 1'b0;
        RSTb = 1'b1;
        repeat (3) cyc();
        chk("t6_after_release", 32'({grey, i_gray, code_valid, dll_lock, lock_err}), 32'd0);
        dll_en = 1'b1; drive_pd();
        cyc();
        chk("t6_entry_cv_low", 32'(code_valid), 32'd0);
        cyc();
        chk("t6_entry_cv_high", 32'(code_valid), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/aibcr3_dll_lock_ctrl.md
Name: aibcr3_dll_lock_ctrl

Overview:
Sequences lock acquisition and tracking for the DLL delay line (64 coarse taps) and 8-phase interpolator.
- Drives coarse Gray code, fine Gray code and the code_valid strobe that feed the DLL code mux.
- Lock is by linear coarse search, then fine search, on a synchronous phase-detector result.
- After lock, tracks drift with a filtered ±1 fine-step loop that carries and borrows into the coarse code.

Parameters:
SETTLE_CYC, 16, CLKIN cycles waited after every code change before pd_up is sampled (≥2)
FILT_LEN, 4, consecutive identical pd_up samples required for one tracking step (≥1)
COARSE_MAX, 63, highest legal coarse code (≤63)

Ports:
CLKIN  input  1  controller clock
RSTb  input  1  asynchronous active-low reset
dll_en  input  1  level; 1 starts or keeps acquisition/tracking, 0 returns to IDLE
pd_up  input  1  phase detector, synchronous to CLKIN; 1 = delay too short (increase), 0 = too long
grey  output  7  coarse code, Gray-encoded, {1'b0, coarse[5:0]} before encoding
i_gray  output  3  fine interpolator code, Gray-encoded
code_valid  output  1  one-cycle strobe, high the cycle after grey/i_gray change
dll_lock  output  1  high in LOCKED
lock_err  output  1  sticky until dll_en=0 or reset; acquisition failed

Behaviour:
- Internal linear code lin[8:0] = {coarse[5:0], fine[2:0]}. All outputs are registered, and grey/i_gray are encoded from the registered lin.
- Reset (async assert, sync release): state IDLE, lin=0, grey=0, i_gray=0, code_valid=0, dll_lock=0, lock_err=0, counters=0.
- Settle counter: loaded on every lin change and counts SETTLE_CYC cycles. pd_up is sampled only on the cycle the counter expires.
- States:
  - IDLE: lin=0. On dll_en=1, go to CSRCH, strobe code_valid, load settle.
  - CSRCH, at each sample:
    - pd_up=1 and coarse<COARSE_MAX: coarse+1, stay.
    - pd_up=1 and coarse=COARSE_MAX: go to ERR.
    - pd_up=0 and coarse=0: go to FSRCH with fine=0 and no code change. Settle is reloaded anyway.
    - pd_up=0 and coarse>0: coarse-1, go to FSRCH. fine is already 0.
  - FSRCH, at each sample:
    - pd_up=1 and fine<7: fine+1.
    - pd_up=1 and fine=7: coarse+1, fine=0, stay in FSRCH. If coarse=COARSE_MAX, go to ERR instead.
    - pd_up=0: go to LOCKED with no code change.
  - LOCKED: dll_lock=1. The filter counter counts consecutive samples of equal pd_up; a change of value restarts the count at 1. When the count reaches FILT_LEN, apply lin±1 (up for pd_up=1) and clear the filter.
    - Increment at lin={COARSE_MAX,7}: saturate, no change, no strobe.
    - Decrement at lin=0: saturate, no change, no strobe.
    - Carry/borrow follow linear arithmetic, e.g. {5,7}+1={6,0}.
    - dll_lock stays 1 while tracking.
  - ERR: lock_err=1, dll_lock=0, lin held. Leave only via dll_en=0.
- dll_en=0 in any state: next cycle go to IDLE. lin=0, dll_lock=0, lock_err=0, code_valid pulses once if lin was non-zero.
- code_valid fires exactly once per lin change, in the cycle after the change. It never fires without a change, except on IDLE→CSRCH entry.
- One lin step per sample at most. Simultaneous dll_en fall and sample: dll_en wins.
- RSTb asserted mid-operation: immediate return to reset values, including asynchronous clearing of the outputs.

Test Plan:
1. Reset, then dll_en=1 with pd_up=1 until coarse reaches 10, then pd_up=0 thereafter → FSRCH at coarse=9, LOCKED with lin={9,0}. grey=Gray(9)=7'b0001101, i_gray=0, dll_lock=1. Each step is spaced SETTLE_CYC+1 cycles and has exactly one code_valid pulse.
2. From lock at {9,0}: pd_up=1 until fine=7, continue pd_up=1 → carry to {10,0}, i_gray=3'b000 and grey=Gray(10). A pd_up=1 run of length FILT_LEN-1 followed by a 0 produces no step.
3. pd_up held at 1 from IDLE → coarse walks to 63, then ERR. lock_err=1, dll_lock=0, and lock_err persists until dll_en=0, after which all outputs are 0.
4. LOCKED at lin=0 with pd_up=0 held → no change and no code_valid. LOCKED at {63,7} with pd_up=1 held → same result.
5. dll_en deasserted during FSRCH at {20,3} → IDLE next cycle with lin=0 and one code_valid. Re-enable restarts the search from 0.
6. RSTb pulsed low mid-CSRCH, asynchronous to the clock edge → outputs clear immediately, and the FSM is in IDLE after release.
